k12a_alu_writeback: RTL
=======================

K12A_ALU_WRITEBACK -- requirements
Module: k12a_alu_writeback

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, SHALL set the number of bus-settle cycles before capture; legal range 1-15.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 wb_start  input  1  request a writeback; sampled only in IDLE.
REQ-005 wb_mode  input  1  0 = register writeback from data_bus; 1 = condition capture from alu_condition.
REQ-006 inst  input  16  current instruction; bits [12:11] select the destination, bit 11 inverts the condition.
REQ-007 data_bus  inout  8  shared bus; this block SHALL only sample it and SHALL never drive it (constant high-Z).
REQ-008 alu_condition  input  1  ALU condition result.
REQ-009 skip_clear  input  1  synchronous clear of skip.
REQ-010 alu_load_n  output  1  active-low ALU bus-drive enable.
REQ-011 a, b, c, d  output  8 each  destination register contents.
REQ-012 skip  output  1  latched condition result.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 wb_done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE and CAPTURE.
REQ-016 In IDLE with wb_start=1 at an edge, the block SHALL latch inst[12:11] and wb_mode, clear the settle counter, and enter SETTLE.
REQ-017 In IDLE with wb_start=0, the block SHALL remain in IDLE.
REQ-018 wb_start while busy=1 SHALL be ignored; no queuing.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CAPTURE.
REQ-020 CAPTURE SHALL last exactly 1 cycle.
REQ-021 At the edge ending CAPTURE, the block SHALL return to IDLE and set wb_done=1 for exactly the following cycle.
REQ-022 Latency SHALL be fixed: start edge at t0 -> destination or skip updated at edge t0+SETTLE_CYCLES+1.
REQ-023 alu_load_n SHALL be a registered output: low throughout SETTLE and CAPTURE when latched mode=0, high otherwise, including the whole of condition mode.
REQ-024 Mode 0: at the edge ending CAPTURE, data_bus SHALL be written to the latched destination (0=a, 1=b, 2=c, 3=d).
REQ-025 Mode 0: the other three registers and skip SHALL be unchanged.
REQ-026 Mode 1: at the edge ending CAPTURE, skip SHALL be loaded with alu_condition XOR latched inst[11]; a-d SHALL be unchanged.
REQ-027 inst changes after the start edge SHALL NOT affect the operation in progress.
REQ-028 skip_clear=1 SHALL clear skip at the edge.
REQ-029 If skip_clear coincides with a mode-1 capture edge, the capture SHALL take priority.
REQ-030 A new wb_start SHALL be accepted in the same cycle wb_done is high (back-to-back throughput = SETTLE_CYCLES+2 cycles per op).
REQ-031 The settle counter SHALL be 4 bits and SHALL NOT wrap within an operation.

Reset
REQ-032 While reset_n=0, the block SHALL immediately force: state IDLE, alu_load_n=1, busy=0, wb_done=0, skip=0, a=b=c=d=8'h00, counter=0.
REQ-033 Reset mid-operation SHALL abort the operation with no register write.
REQ-034 After reset_n rises, the first start SHALL be accepted on the first rising edge with reset_n=1.

Verification
REQ-035 SETTLE_CYCLES=1; reset; start mode0, inst[12:11]=2, bus=8'hA5 -> alu_load_n low 2 cycles; c=8'hA5 at t0+2; wb_done pulse at t0+2; a=b=d=0.
REQ-036 Start mode1, inst[11]=1, alu_condition=0 -> skip=1 at t0+2; alu_load_n never low; then skip_clear=1 -> skip=0.
REQ-037 Start plus a second wb_start during SETTLE, and inst changed mid-op -> exactly one write, to the originally latched destination.
REQ-038 Back-to-back starts to a then b (bus 8'h11 then 8'h22) -> a=8'h11, b=8'h22, two wb_done pulses 3 cycles apart.
REQ-039 reset_n low during CAPTURE with bus=8'hFF -> alu_load_n=1 immediately; destination stays 8'h00; no wb_done.
REQ-040 SETTLE_CYCLES=4; mode1 capture coincident with skip_clear, alu_condition=1, inst[11]=0 -> skip=1 at t0+5.

Source files
------------

// File: rtl/k12a_alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : k12a_alu_writeback
//  Description : ALU result writeback sequencer. On a start request it lets
//                the shared data bus settle for SETTLE_CYCLES cycles, then
//                spends one capture cycle. At the end of capture it either
//                writes the bus value into one of four 8-bit registers
//                (register mode) or latches the ALU condition into the skip
//                flag (condition mode).
//  Revision    : 1.0  initial release
// ============================================================================
module k12a_alu_writeback #(
   // Bus-settle cycles before capture; legal range 1..15. The 4-bit settle
   // counter only needs to reach SETTLE_CYCLES-1, so it never wraps.
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        wb_start,
   input  logic        wb_mode,
   input  logic [15:0] inst,
   inout  wire  [7:0]  data_bus,
   input  logic        alu_condition,
   input  logic        skip_clear,
   output logic        alu_load_n,
   output logic [7:0]  a,
   output logic [7:0]  b,
   output logic [7:0]  c,
   output logic [7:0]  d,
   output logic        skip,
   output logic        busy,
   output logic        wb_done
);

   // Last value of the settle counter before moving on to capture.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   // Writeback sequencer states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic [1:0]  dest_q;
   logic [1:0]  dest_d;
   logic        mode_q;
   logic        mode_d;
   logic        load_n_d;
   logic        done_d;

   // Capture strobes, decoded from the state register.
   logic        capture_edge;
   logic        reg_write;
   logic        skip_load;
   logic [3:0]  dest_sel;
   logic [7:0]  bus_value;

   // Instruction bits that play no role in writeback.
   logic        unused_inst_bits;

   // The bus belongs to the ALU and other sources; this block only listens.
   assign data_bus  = 8'bzzzz_zzzz;
   assign bus_value = data_bus;

   assign unused_inst_bits = &{1'b0, inst[15:13], inst[10:0]};

   assign busy         = (state_q != IDLE);
   assign capture_edge = (state_q == CAPTURE);
   assign reg_write    = capture_edge && !mode_q;
   assign skip_load    = capture_edge &&  mode_q;

   // One-hot destination select from the latched inst[12:11].
   always_comb begin
      dest_sel = 4'b0000;
      dest_sel[dest_q] = 1'b1;
   end

   // Next-state, settle counter, latched operation and registered outputs.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dest_d   = dest_q;
      mode_d   = mode_q;
      load_n_d = alu_load_n;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            load_n_d = 1'b1;
            if (wb_start) begin
               state_d  = SETTLE;
               cnt_d    = 4'd0;
               dest_d   = inst[12:11];
               mode_d   = wb_mode;
               // ALU drives the bus only for register writebacks.
               load_n_d = wb_mode;
            end
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         CAPTURE: begin
            state_d  = IDLE;
            load_n_d = 1'b1;
            done_d   = 1'b1;
         end
         default: begin
            state_d  = IDLE;
            load_n_d = 1'b1;
         end
      endcase
   end

   // Sequencer state register and latched operation fields.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         dest_q     <= 2'd0;
         mode_q     <= 1'b0;
         alu_load_n <= 1'b1;
         wb_done    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dest_q     <= dest_d;
         mode_q     <= mode_d;
         alu_load_n <= load_n_d;
         wb_done    <= done_d;
      end
   end

   // Register a: loaded from the bus when it is the captured destination.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a <= 8'h00;
      end else if (reg_write && dest_sel[0]) begin
         a <= bus_value;
      end
   end

   // Register b: loaded from the bus when it is the captured destination.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         b <= 8'h00;
      end else if (reg_write && dest_sel[1]) begin
         b <= bus_value;
      end
   end

   // Register c: loaded from the bus when it is the captured destination.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         c <= 8'h00;
      end else if (reg_write && dest_sel[2]) begin
         c <= bus_value;
      end
   end

   // Register d: loaded from the bus when it is the captured destination.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         d <= 8'h00;
      end else if (reg_write && dest_sel[3]) begin
         d <= bus_value;
      end
   end

   // Skip flag: condition capture wins over a simultaneous clear.
   // inst[11] is dest_q[0], which inverts the condition sense.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         skip <= 1'b0;
      end else if (skip_load) begin
         skip <= alu_condition ^ dest_q[0];
      end else if (skip_clear) begin
         skip <= 1'b0;
      end
   end

endmodule
`default_nettype wire
